// File: rtl/ray_aabb_hit_collector.sv
// Turns the per-cycle hit_miss stream of the ray/AABB core into one result record per ray.
// Sideband (valid/id/last) rides a delay line matching the core latency; records queue in a FIFO.
module ray_aabb_hit_collector #(
    parameter int LATENCY    = 34,
    parameter int ID_W       = 16,
    parameter int BIDX_W     = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ID_W-1:0]   in_ray_id,
    input  logic              in_last,
    output logic              in_ready,
    input  logic              hit_miss,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ID_W-1:0]   out_ray_id,
    output logic              out_hit,
    output logic [BIDX_W-1:0] out_hit_count,
    output logic [BIDX_W-1:0] out_first_idx,
    output logic              overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(LATENCY + FIFO_DEPTH + 1);
    localparam int REC_W = ID_W + 1 + 2 * BIDX_W;
    localparam logic [BIDX_W-1:0] BIDX_MAX = '1;
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [LATENCY-1:0] dl_valid_q, dl_valid_d;
    logic [LATENCY-1:0] dl_last_q, dl_last_d;
    logic [ID_W-1:0]    dl_id_q [LATENCY];
    logic [ID_W-1:0]    dl_id_d [LATENCY];

    logic [BIDX_W-1:0]  box_idx_q, box_idx_d;
    logic               acc_hit_q, acc_hit_d;
    logic [BIDX_W-1:0]  acc_cnt_q, acc_cnt_d;
    logic [BIDX_W-1:0]  acc_first_q, acc_first_d;

    logic [REC_W-1:0]   mem_q [FIFO_DEPTH];
    logic [REC_W-1:0]   mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     fifo_count_q, fifo_count_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic               overflow_q, overflow_d;

    logic               d_valid, d_last, rec_push, pop, full, do_push, issue_last;
    logic [ID_W-1:0]    d_id;
    logic               new_hit;
    logic [BIDX_W-1:0]  new_cnt, new_first;

    assign d_valid    = dl_valid_q[LATENCY-1];
    assign d_last     = dl_last_q[LATENCY-1];
    assign d_id       = dl_id_q[LATENCY-1];
    assign rec_push   = d_valid & d_last;
    assign issue_last = in_valid & in_last;
    assign out_valid  = (fifo_count_q != '0);
    assign pop        = out_valid & out_ready;
    assign full       = (fifo_count_q == FULL_CNT);
    assign do_push    = rec_push & (~full | pop);

    assign new_hit   = acc_hit_q | hit_miss;
    assign new_cnt   = (hit_miss && acc_cnt_q != BIDX_MAX) ? acc_cnt_q + 1'b1 : acc_cnt_q;
    assign new_first = (!acc_hit_q && hit_miss) ? box_idx_q : acc_first_q;

    always_comb begin
        dl_valid_d = {dl_valid_q[LATENCY-2:0], in_valid};
        dl_last_d  = {dl_last_q[LATENCY-2:0], in_last};
        dl_id_d[0] = in_ray_id;
        for (int i = 1; i < LATENCY; i++) begin
            dl_id_d[i] = dl_id_q[i-1];
        end

        box_idx_d   = box_idx_q;
        acc_hit_d   = acc_hit_q;
        acc_cnt_d   = acc_cnt_q;
        acc_first_d = acc_first_q;
        if (d_valid) begin
            if (d_last) begin
                box_idx_d   = '0;
                acc_hit_d   = 1'b0;
                acc_cnt_d   = '0;
                acc_first_d = '0;
            end else begin
                box_idx_d   = (box_idx_q == BIDX_MAX) ? box_idx_q : box_idx_q + 1'b1;
                acc_hit_d   = new_hit;
                acc_cnt_d   = new_cnt;
                acc_first_d = new_first;
            end
        end

        // A full FIFO can still take a record when the head leaves in the same cycle.
        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = {d_id, new_hit, new_cnt, new_first};
        end
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({do_push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 1'b1;
            2'b01:   fifo_count_d = fifo_count_q - 1'b1;
            default: fifo_count_d = fifo_count_q;
        endcase

        case ({issue_last, rec_push})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase

        overflow_d = overflow_q | (rec_push & full & ~pop);
    end

    assign {out_ray_id, out_hit, out_hit_count, out_first_idx} = mem_q[rd_ptr_q];
    assign in_ready = (CNT_W'(fifo_count_q) + inflight_q) < CNT_W'(FIFO_DEPTH);
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid_q   <= '0;
            dl_last_q    <= '0;
            for (int i = 0; i < LATENCY; i++) dl_id_q[i] <= '0;
            box_idx_q    <= '0;
            acc_hit_q    <= 1'b0;
            acc_cnt_q    <= '0;
            acc_first_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            inflight_q   <= '0;
            overflow_q   <= 1'b0;
        end else begin
            dl_valid_q   <= dl_valid_d;
            dl_last_q    <= dl_last_d;
            dl_id_q      <= dl_id_d;
            box_idx_q    <= box_idx_d;
            acc_hit_q    <= acc_hit_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_first_q  <= acc_first_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
            inflight_q   <= inflight_d;
            overflow_q   <= overflow_d;
        end
    end

endmodule

// File: tb/tb_ray_aabb_hit_collector.sv
// Scoreboard bench for ray_aabb_hit_collector: a behavioural core model replays hit_miss
// LATENCY cycles after each test, and expected records are queued at issue time.
module tb_ray_aabb_hit_collector;

    localparam int L = 34;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_ray_id = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic        hit_miss = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_ray_id;
    logic        out_hit;
    logic [7:0]  out_hit_count;
    logic [7:0]  out_first_idx;
    logic        overflow;

    ray_aabb_hit_collector #(.LATENCY(L), .ID_W(16), .BIDX_W(8), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ray_id(in_ray_id), .in_last(in_last), .in_ready(in_ready),
        .hit_miss(hit_miss),
        .out_valid(out_valid), .out_ready(out_ready), .out_ray_id(out_ray_id),
        .out_hit(out_hit), .out_hit_count(out_hit_count), .out_first_idx(out_first_idx),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] id;
        logic        hit;
        logic [7:0]  cnt;
        logic [7:0]  first;
    } rec_t;

    rec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   rnd_ready = 0;
    logic hm_sched [256];
    int   m_idx = 0;
    logic m_hit = 1'b0;
    int   m_cnt = 0;
    int   m_first = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock of stimulus; the core model returns this test's hit L cycles later.
    task automatic applyStimulus(input logic v, input logic [15:0] id, input logic last, input logic hit);
        in_valid  = v;
        in_ray_id = id;
        in_last   = last;
        if (rnd_ready) out_ready = ($urandom_range(0, 1) == 1);
        hm_sched[(cyc + L) % 256] = v & hit;
        @(posedge clk);
        cyc++;
        #1;
        hit_miss = hm_sched[cyc % 256];
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic issueBox(input logic [15:0] id, input logic last, input logic hit,
                            input bit legal, input bit keep);
        rec_t r;
        if (last && legal) begin
            for (int g = 0; g < 500 && !in_ready; g++) idle(1);
            if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
        end
        if (hit && !m_hit) m_first = (m_idx > 255) ? 255 : m_idx;
        if (hit) m_hit = 1'b1;
        if (hit && m_cnt < 255) m_cnt++;
        if (last) begin
            r.id = id; r.hit = m_hit; r.cnt = 8'(m_cnt); r.first = 8'(m_first);
            if (keep) sb.push_back(r);
            m_idx = 0; m_hit = 1'b0; m_cnt = 0; m_first = 0;
        end else begin
            m_idx++;
        end
        applyStimulus(1'b1, id, last, hit);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        sb.delete();
        m_idx = 0; m_hit = 1'b0; m_cnt = 0; m_first = 0;
    endtask

    task automatic waitDrain();
        for (int g = 0; g < 300 && (sb.size() != 0 || out_valid); g++) idle(1);
        checkOutput("drain_done", 32'(sb.size() == 0 && !out_valid), 32'd1);
    endtask

    task automatic checkResetState();
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_ray_id", 32'(out_ray_id), 32'd0);
        checkOutput("rst_out_hit", 32'(out_hit), 32'd0);
        checkOutput("rst_hit_count", 32'(out_hit_count), 32'd0);
        checkOutput("rst_first_idx", 32'(out_first_idx), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
    endtask

    // Every accepted record is compared against the head of the scoreboard.
    always @(negedge clk) begin : monitor
        rec_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_record", 32'(out_ray_id), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                checkOutput("rec_id", 32'(out_ray_id), 32'(e.id));
                checkOutput("rec_hit", 32'(out_hit), 32'(e.hit));
                checkOutput("rec_count", 32'(out_hit_count), 32'(e.cnt));
                checkOutput("rec_first", 32'(out_first_idx), 32'(e.first));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        for (int i = 0; i < 256; i++) hm_sched[i] = 1'b0;
        doReset();
        checkResetState();

        // Single 4-box ray, hits on boxes 1 and 3: record appears 35 cycles after the last test.
        t0 = cyc;
        issueBox(16'h0005, 1'b0, 1'b0, 1, 1);
        issueBox(16'h0005, 1'b0, 1'b1, 1, 1);
        issueBox(16'h0005, 1'b0, 1'b0, 1, 1);
        issueBox(16'h0005, 1'b1, 1'b1, 1, 1);
        while (cyc < t0 + 37) idle(1);
        checkOutput("latency_early", 32'(out_valid), 32'd0);
        idle(1);
        checkOutput("latency_on_time", 32'(out_valid), 32'd1);
        checkOutput("ray5_count_const", 32'(out_hit_count), 32'd2);
        checkOutput("ray5_first_const", 32'(out_first_idx), 32'd1);
        out_ready = 1'b1;
        waitDrain();

        // Miss-only ray followed back-to-back by a single-box hit.
        for (int b = 0; b < 3; b++) issueBox(16'h0007, b == 2, 1'b0, 1, 1);
        issueBox(16'h0008, 1'b1, 1'b1, 1, 1);
        waitDrain();

        // Back-pressure: credits run out after 8 single-box rays.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput("credit_ready", 32'(in_ready), 32'd1);
            issueBox(16'h0010 + 16'(i), 1'b1, 1'(i % 2), 1, 1);
        end
        checkOutput("credit_exhausted", 32'(in_ready), 32'd0);
        idle(L + 2);
        checkOutput("full_out_valid", 32'(out_valid), 32'd1);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        checkOutput("full_no_overflow", 32'(overflow), 32'd0);

        // Record arrives while full but the head leaves in the same cycle.
        issueBox(16'h0042, 1'b1, 1'b1, 0, 1);
        idle(L - 1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        idle(2);
        checkOutput("push_pop_no_overflow", 32'(overflow), 32'd0);
        checkOutput("push_pop_still_full", 32'(in_ready), 32'd0);

        // Illegal issue into a full FIFO with no consumer: record dropped, overflow sticky.
        issueBox(16'h0099, 1'b1, 1'b1, 0, 0);
        idle(L + 2);
        checkOutput("overflow_set", 32'(overflow), 32'd1);
        checkOutput("overflow_head_id", 32'(out_ray_id), 32'h0011);
        out_ready = 1'b1;
        waitDrain();
        checkOutput("overflow_sticky", 32'(overflow), 32'd1);
        checkOutput("ready_after_drain", 32'(in_ready), 32'd1);

        // Reset with a record pending and a ray half-issued.
        out_ready = 1'b0;
        issueBox(16'h002F, 1'b1, 1'b1, 1, 1);
        idle(L + 2);
        issueBox(16'h0030, 1'b0, 1'b1, 1, 1);
        issueBox(16'h0030, 1'b0, 1'b0, 1, 1);
        doReset();
        checkResetState();
        out_ready = 1'b1;
        issueBox(16'h0031, 1'b0, 1'b0, 1, 1);
        issueBox(16'h0031, 1'b0, 1'b0, 1, 1);
        issueBox(16'h0031, 1'b0, 1'b1, 1, 1);
        issueBox(16'h0031, 1'b1, 1'b1, 1, 1);
        waitDrain();

        // Random rays with a randomly stalling consumer.
        rnd_ready = 1;
        for (int r = 0; r < 20; r++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++)
                issueBox(16'h0100 + 16'(r), b == len - 1, $urandom_range(0, 3) == 0, 1, 1);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
        end
        rnd_ready = 0;
        out_ready = 1'b1;
        waitDrain();
        checkOutput("final_overflow", 32'(overflow), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
